// File: rtl/desc_sche_rr.sv
// Multi-app descriptor scheduler: counts pending descriptors per app, arbitrates among
// eligible apps, fetches one descriptor at a time from the QM and forwards it downstream.
`ifndef RL_DESC_WIDTH
`define RL_DESC_WIDTH 64
`endif

module desc_sche_rr #(
    parameter int unsigned APP_ID_WIDTH = 2,
    parameter int unsigned DESC_WIDTH   = `RL_DESC_WIDTH,
    parameter int unsigned CNT_WIDTH    = 5,
    parameter int unsigned ARB_MODE     = 0,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [APP_ID_WIDTH-1:0]        s_notify_app_id,
    input  logic                           s_notify_valid,
    output logic                           s_notify_ready,
    input  logic [(1<<APP_ID_WIDTH)-1:0]   s_app_mask,
    output logic                           qm_req_valid,
    output logic [APP_ID_WIDTH-1:0]        qm_req_app_id,
    input  logic                           qm_req_ready,
    input  logic [DESC_WIDTH-1:0]          qm_desc,
    input  logic                           qm_desc_valid,
    output logic [DESC_WIDTH-1:0]          m_desc,
    output logic [APP_ID_WIDTH-1:0]        m_desc_app_id,
    output logic                           m_desc_valid,
    input  logic                           m_desc_ready,
    output logic                           stat_timeout,
    output logic                           stat_stray
);

    localparam int unsigned APP_COUNT = 1 << APP_ID_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam int unsigned TMR_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t                  r_state;
    logic [CNT_WIDTH-1:0]    r_cnt [APP_COUNT];
    logic [APP_ID_WIDTH-1:0] r_ptr;
    logic [APP_ID_WIDTH-1:0] r_sel;
    logic [TMR_WIDTH-1:0]    r_timer;
    logic                    r_req_valid;
    logic [DESC_WIDTH-1:0]   r_m_desc;
    logic [APP_ID_WIDTH-1:0] r_m_app;
    logic                    r_m_valid;
    logic                    r_timeout;
    logic                    r_stray;

    logic                    w_notify_acc;
    logic                    w_grant;
    logic [APP_COUNT-1:0]    w_inc;
    logic [APP_COUNT-1:0]    w_dec;
    logic [APP_COUNT-1:0]    w_elig;
    logic [APP_ID_WIDTH-1:0] w_win;

    // Ready looks only at the addressed counter, never at the grant path.
    assign s_notify_ready = !rst && (r_cnt[s_notify_app_id] != CNT_MAX);
    assign w_notify_acc   = s_notify_valid && s_notify_ready;
    assign w_grant        = (r_state == ST_REQ) && qm_req_ready;

    always_comb begin
        w_inc  = '0;
        w_dec  = '0;
        w_elig = '0;
        for (int i = 0; i < APP_COUNT; i++) begin
            w_inc[i]  = w_notify_acc && (s_notify_app_id == APP_ID_WIDTH'(i));
            w_dec[i]  = w_grant && (r_sel == APP_ID_WIDTH'(i));
            w_elig[i] = (r_cnt[i] != '0) && s_app_mask[i];
        end
    end

    // Downward scans so the last hit is the highest-priority candidate.
    always_comb begin
        w_win = '0;
        if (ARB_MODE == 32'd1) begin
            for (int i = APP_COUNT - 1; i >= 0; i--) begin
                if (w_elig[i]) begin
                    w_win = APP_ID_WIDTH'(i);
                end
            end
        end else begin
            for (int k = APP_COUNT; k >= 1; k--) begin
                if (w_elig[APP_ID_WIDTH'(int'(r_ptr) + k)]) begin
                    w_win = APP_ID_WIDTH'(int'(r_ptr) + k);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < APP_COUNT; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < APP_COUNT; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= APP_ID_WIDTH'(APP_COUNT - 1);
            r_sel       <= '0;
            r_timer     <= '0;
            r_req_valid <= 1'b0;
            r_m_desc    <= '0;
            r_m_app     <= '0;
            r_m_valid   <= 1'b0;
            r_timeout   <= 1'b0;
            r_stray     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            r_stray   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_stray <= qm_desc_valid;
                    if (|w_elig) begin
                        r_sel       <= w_win;
                        r_req_valid <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    r_stray <= qm_desc_valid;
                    if (qm_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_ptr       <= r_sel;
                        r_timer     <= '0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (qm_desc_valid) begin
                        r_m_desc  <= qm_desc;
                        r_m_app   <= r_sel;
                        r_m_valid <= 1'b1;
                        r_state   <= ST_OUT;
                    end else if (r_timer == TMR_LAST) begin
                        // Abandoned: the consumed count stays consumed.
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_WIDTH'(1);
                    end
                end
                ST_OUT: begin
                    r_stray <= qm_desc_valid;
                    if (m_desc_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign qm_req_valid  = r_req_valid;
    assign qm_req_app_id = r_sel;
    assign m_desc        = r_m_desc;
    assign m_desc_app_id = r_m_app;
    assign m_desc_valid  = r_m_valid;
    assign stat_timeout  = r_timeout;
    assign stat_stray    = r_stray;

endmodule
